// File: rtl/servo_pos_bank_if.sv
// rtl/servo_pos_bank_if.sv - host/PWM-side bundle for the servo position bank
// Signals:
//   servo_num, servo_pos, new_pos   shadow-bank write request
//   commit                          request shadow->target transfer at next frame
//   frame_sync                      one-cycle start-of-frame pulse from the PWM side
//   pos_buffer                      slew-limited positions, channel i at [i*POS_WIDTH +: POS_WIDTH]
//   pending, moving, idx_err        status
// Modports: master drives requests and observes status; slave is the bank itself.
interface servo_pos_bank_if #(
  parameter int NUM_SERVOS = 8,
  parameter int POS_WIDTH  = 8,
  parameter int IDX_WIDTH  = 6
);
  logic [IDX_WIDTH-1:0]            servo_num;
  logic [POS_WIDTH-1:0]            servo_pos;
  logic                            new_pos;
  logic                            commit;
  logic                            frame_sync;
  logic [POS_WIDTH*NUM_SERVOS-1:0] pos_buffer;
  logic                            pending;
  logic                            moving;
  logic                            idx_err;

  modport master (
    output servo_num, servo_pos, new_pos, commit, frame_sync,
    input  pos_buffer, pending, moving, idx_err
  );

  modport slave (
    input  servo_num, servo_pos, new_pos, commit, frame_sync,
    output pos_buffer, pending, moving, idx_err
  );
endinterface

// File: rtl/servo_pos_bank.sv
// rtl/servo_pos_bank.sv - double-buffered servo position store with per-frame slew limiting
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-low reset
//   bus  slave servo_pos_bank_if: writes, commit and frame_sync in; positions and status out
// Writes land in the shadow bank; a commit moves the whole shadow bank into the
// target bank on the next frame_sync. On every frame_sync each output steps
// toward its (pre-transfer) target by at most MAX_STEP counts.
module servo_pos_bank #(
  parameter int NUM_SERVOS = 8,
  parameter int POS_WIDTH  = 8,
  parameter int IDX_WIDTH  = 6,
  parameter int MAX_STEP   = 4,
  parameter int RESET_POS  = 128
) (
  input  logic            clk,
  input  logic            rst,
  servo_pos_bank_if.slave bus
);

  localparam logic [POS_WIDTH-1:0] RST_VAL   = POS_WIDTH'(RESET_POS);
  localparam logic [POS_WIDTH-1:0] STEP_VAL  = POS_WIDTH'(MAX_STEP);
  localparam logic [POS_WIDTH:0]   STEP_WIDE = (POS_WIDTH+1)'(MAX_STEP);
  // One extra bit so NUM_SERVOS = 2^IDX_WIDTH is representable.
  localparam logic [IDX_WIDTH:0]   NUM_WIDE  = (IDX_WIDTH+1)'(NUM_SERVOS);

  logic [POS_WIDTH-1:0] shadow_q [NUM_SERVOS];
  logic [POS_WIDTH-1:0] shadow_d [NUM_SERVOS];
  logic [POS_WIDTH-1:0] target_q [NUM_SERVOS];
  logic [POS_WIDTH-1:0] target_d [NUM_SERVOS];
  logic [POS_WIDTH-1:0] out_q    [NUM_SERVOS];
  logic [POS_WIDTH-1:0] out_d    [NUM_SERVOS];

  logic pending_q, pending_d;
  logic moving_q,  moving_d;
  logic idx_err_q, idx_err_d;

  logic wr_ok;
  logic transfer;

  logic [POS_WIDTH*NUM_SERVOS-1:0] pos_flat;

  // Control: write qualification, transfer decision, commit bookkeeping.
  always_comb begin
    wr_ok     = bus.new_pos && ({1'b0, bus.servo_num} < NUM_WIDE);
    // A commit arriving together with frame_sync transfers immediately.
    transfer  = bus.frame_sync && (pending_q || bus.commit);
    pending_d = transfer ? 1'b0 : (pending_q || bus.commit);
    idx_err_d = bus.new_pos && !wr_ok;
  end

  // Shadow and target banks. The transfer copies shadow_q, so a write in the
  // same cycle only reaches the shadow bank.
  always_comb begin
    for (int i = 0; i < NUM_SERVOS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_ok && (bus.servo_num == IDX_WIDTH'(i))) begin
        shadow_d[i] = bus.servo_pos;
      end
      target_d[i] = transfer ? shadow_q[i] : target_q[i];
    end
  end

  // Slew stage. Works against target_q, i.e. the target in force before any
  // transfer at this edge, so a new batch starts moving one frame later.
  always_comb begin
    logic signed [POS_WIDTH:0] diff;
    logic        [POS_WIDTH:0] mag;
    for (int i = 0; i < NUM_SERVOS; i++) begin
      // Zero-extend both operands into POS_WIDTH+1 bits: the difference cannot overflow.
      diff     = $signed({1'b0, target_q[i]}) - $signed({1'b0, out_q[i]});
      mag      = diff[POS_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      out_d[i] = out_q[i];
      if (bus.frame_sync) begin
        if ((MAX_STEP == 0) || (mag <= STEP_WIDE)) begin
          out_d[i] = target_q[i];
        end else if (diff[POS_WIDTH]) begin
          out_d[i] = out_q[i] - STEP_VAL;
        end else begin
          out_d[i] = out_q[i] + STEP_VAL;
        end
      end
    end
  end

  // moving is a registered view of the current out/target mismatch.
  always_comb begin
    moving_d = 1'b0;
    for (int i = 0; i < NUM_SERVOS; i++) begin
      if (out_q[i] != target_q[i]) begin
        moving_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SERVOS; i++) begin
        shadow_q[i] <= RST_VAL;
        target_q[i] <= RST_VAL;
        out_q[i]    <= RST_VAL;
      end
      pending_q <= 1'b0;
      moving_q  <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SERVOS; i++) begin
        shadow_q[i] <= shadow_d[i];
        target_q[i] <= target_d[i];
        out_q[i]    <= out_d[i];
      end
      pending_q <= pending_d;
      moving_q  <= moving_d;
      idx_err_q <= idx_err_d;
    end
  end

  always_comb begin
    pos_flat = '0;
    for (int i = 0; i < NUM_SERVOS; i++) begin
      pos_flat[i*POS_WIDTH +: POS_WIDTH] = out_q[i];
    end
  end

  assign bus.pos_buffer = pos_flat;
  assign bus.pending    = pending_q;
  assign bus.moving     = moving_q;
  assign bus.idx_err    = idx_err_q;

endmodule

// File: doc/servo_pos_bank.md
# servo_pos_bank

Parametrised, double-buffered servo position store with per-frame slew limiting. It sits between the host command decoder and the PWM generators. Host writes go to a shadow bank and move to the target bank atomically on a frame boundary after a commit. Each output channel then steps toward its target by at most `MAX_STEP` counts per PWM frame, so all servos in a committed batch start moving in the same frame.

## Interface
- `NUM_SERVOS`, default 8: number of channels; 1..2^`IDX_WIDTH`.
- `POS_WIDTH`, default 8: position width in bits, unsigned.
- `IDX_WIDTH`, default 6: width of the channel index.
- `MAX_STEP`, default 4: maximum output change per frame. 0 means no limit (output jumps to target).
- `RESET_POS`, default 128: reset value of every shadow, target and output position.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `servo_num`  in  `IDX_WIDTH`  channel index for a write.
- `servo_pos`  in  `POS_WIDTH`  position for a write.
- `new_pos`  in  1  write strobe; one write per cycle it is high.
- `commit`  in  1  request transfer of shadow bank to target bank at the next frame boundary.
- `frame_sync`  in  1  one-cycle pulse from the PWM generator at the start of each frame.
- `pos_buffer`  out  `POS_WIDTH*NUM_SERVOS`  slew-limited positions; channel i occupies bits [i*`POS_WIDTH` +: `POS_WIDTH`].
- `pending`  out  1  a commit is waiting for `frame_sync`.
- `moving`  out  1  at least one output differs from its target.
- `idx_err`  out  1  one-cycle pulse: a write addressed an index ≥ `NUM_SERVOS`.

## Operation
- **Shadow bank (`NUM_SERVOS` × `POS_WIDTH`)**
  - `new_pos` with `servo_num` < `NUM_SERVOS`: `shadow[servo_num]` ← `servo_pos`.
  - `new_pos` with an out-of-range index: no write; `idx_err` = 1 in the next cycle.
- **Commit**
  - `commit` sets `pending`.
  - On `frame_sync` with (`pending` | `commit`): every target ← its shadow value, and `pending` clears.
  - `commit` in the same cycle as `frame_sync` transfers at that same edge; `pending` stays 0.
- **Same-cycle `new_pos` and transfer:** the transfer copies the pre-write shadow. The new value lands in shadow only and needs a later commit.
- **Slew stage, on each `frame_sync`, per channel:**
  - Uses the target value held before that edge's transfer.
  - d = target − out, computed as signed `POS_WIDTH`+1 bits, so it cannot overflow.
  - If |d| ≤ `MAX_STEP` or `MAX_STEP` = 0: out ← target.
  - Otherwise: out ← out ± `MAX_STEP`, toward target.
  - Output never overshoots the target and never wraps; all arithmetic is unsigned at the result.
- **Between frame_sync pulses:** outputs hold.
- **`moving`:** registered OR over channels of (out ≠ target), updated every cycle.

## Timing
- **Reset (`rst` low, asynchronous):**
  - All shadow, target and outputs = `RESET_POS`.
  - `pending`, `moving` and `idx_err` = 0.
  - Reset mid-transfer or mid-slew abandons the operation completely; no partial state survives.
- **Write latency:** shadow updates 1 cycle after `new_pos`.
- **`idx_err`:** high exactly 1 cycle, in the cycle after the bad write.
- **`pending`:** rises the cycle after `commit`; falls the cycle after the transferring `frame_sync`.
- **Frame latency:**
  - Transfer happens at frame N.
  - First output step happens at frame N+1.
  - A change of k counts finishes after ceil(k/`MAX_STEP`) frames from N+1.
- **`moving`:** reflects the state from the previous cycle (1-cycle registered lag).
- **Back-to-back events:** writes to the same channel in consecutive cycles are last-wins. A repeated `commit` while `pending` = 1 has no extra effect.

## Test plan
- **Reset values:** assert `rst` = 0, release.
  - All channels of `pos_buffer` = 128; `pending`, `moving` and `idx_err` = 0.
  - Assert `rst` again mid-slew: all channels back to 128 immediately, without waiting for `clk`.
- **Slew ramp:** write ch2 = 140, `commit`, then pulse `frame_sync` four times.
  - ch2 output 128 (transfer frame), then 132, 136, 140.
  - `moving` = 1 from the cycle after the transfer until the cycle after it reaches 140; other channels stay 128.
- **Descending with clamp:** target ch0 = 126 from 128, `MAX_STEP` = 4.
  - After one stepping frame ch0 = 126, with no overshoot.
  - Repeat with `MAX_STEP` = 0 and target 0: ch0 = 0 after one stepping frame.
- **Atomic batch:** write ch1 = 200 and ch3 = 50, no commit, several `frame_sync` pulses.
  - Outputs unchanged at 128.
  - Then `commit`: `pending` = 1 until the next `frame_sync`. Both channels begin stepping at the same later frame (ch1 132, ch3 124).
- **Simultaneous events:** in one cycle, `new_pos` ch1 = 10 plus `commit` plus `frame_sync`, with shadow ch1 = 60 beforehand.
  - Target ch1 = 60 and `pending` = 0; shadow ch1 = 10.
- **Bad index:** `NUM_SERVOS` = 8, write `servo_num` = 8 and `servo_num` = 63.
  - `idx_err` pulses for one cycle after each write.
  - No shadow entry changes; checked with a commit and `frame_sync` showing no target change.
